// File: rtl/decoder_nx_scan.sv
// ---------------------------------------------------------------------------
// decoder_nx_scan
//   N-to-2**N one-hot decoder with two operating modes:
//     direct decode : result follows the last loaded select value.
//     auto-scan     : the asserted bit walks 0..OUT_W-1, holding each index
//                     for (dwell+1) clock cycles, and wraps back to 0.
//   All outputs are registered. There is no combinational path from any
//   input to any output.
//
// Parameters
//   N          select width
//   OUT_W      output width (derived as 2**N, do not override)
//   DWELL_W    width of the scan dwell count
//   ACTIVE_LOW 1 = result bits are active-low
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         block enable; 0 returns the block to IDLE
//   mode       0 = direct decode, 1 = auto-scan
//   in         select value, loaded when in_valid = 1
//   in_valid   load strobe for in
//   dwell      scan step period minus 1, in clk cycles
//   result     one-hot decode of idx (polarity set by ACTIVE_LOW)
//   idx        index of the asserted result bit
//   out_valid  high while result carries a decoded value
//   wrap       one-cycle pulse when the scan index wraps OUT_W-1 -> 0
// ---------------------------------------------------------------------------
module decoder_nx_scan #(
   parameter int N          = 2,
   parameter int OUT_W      = 2**N,
   parameter int DWELL_W    = 8,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               mode,
   input  logic [N-1:0]       in,
   input  logic               in_valid,
   input  logic [DWELL_W-1:0] dwell,
   output logic [OUT_W-1:0]   result,
   output logic [N-1:0]       idx,
   output logic               out_valid,
   output logic               wrap
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   // Value of result when no bit is asserted.
   localparam logic [OUT_W-1:0] RESULT_OFF = {OUT_W{ACTIVE_LOW}};

   state_t             state;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [N-1:0]       idx_inc;

   // N-bit addition wraps OUT_W-1 -> 0 on its own since OUT_W = 2**N.
   assign idx_inc = idx + 1'b1;

   // One-hot encode with output polarity applied.
   function automatic logic [OUT_W-1:0] encode(input logic [N-1:0] sel);
      logic [OUT_W-1:0] onehot;
      onehot      = '0;
      onehot[sel] = 1'b1;
      return ACTIVE_LOW ? ~onehot : onehot;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         result    <= RESULT_OFF;
         idx       <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
         dwell_cnt <= '0;
      end else begin
         // wrap is a single-cycle pulse; only the scan advance raises it.
         wrap <= 1'b0;

         if (!en) begin
            // Disable wins over every other input in the same cycle; idx
            // keeps its last value so software can still read it.
            state     <= IDLE;
            result    <= RESULT_OFF;
            out_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (mode) begin
                     state     <= SCAN;
                     idx       <= '0;
                     result    <= encode('0);
                     dwell_cnt <= dwell;
                     out_valid <= 1'b1;
                  end else if (in_valid) begin
                     state     <= DIRECT;
                     idx       <= in;
                     result    <= encode(in);
                     out_valid <= 1'b1;
                  end
               end

               DIRECT: begin
                  if (mode) begin
                     state     <= SCAN;
                     idx       <= '0;
                     result    <= encode('0);
                     dwell_cnt <= dwell;
                  end else if (in_valid) begin
                     idx    <= in;
                     result <= encode(in);
                  end
               end

               SCAN: begin
                  if (!mode) begin
                     // Leaving scan keeps the current position unless a new
                     // select arrives in the same cycle.
                     state <= DIRECT;
                     if (in_valid) begin
                        idx    <= in;
                        result <= encode(in);
                     end
                  end else if (dwell_cnt == '0) begin
                     // The period of the next step uses dwell as sampled now.
                     idx       <= idx_inc;
                     result    <= encode(idx_inc);
                     dwell_cnt <= dwell;
                     wrap      <= &idx;
                  end else begin
                     dwell_cnt <= dwell_cnt - 1'b1;
                  end
               end

               default: begin
                  state     <= IDLE;
                  result    <= RESULT_OFF;
                  out_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_decoder_nx_scan.sv
// ---------------------------------------------------------------------------
// tb_decoder_nx_scan
//   Self-checking bench for decoder_nx_scan (N=2, DWELL_W=8). Two instances
//   share all inputs: one active-high, one ACTIVE_LOW=1. Directed sequences
//   cover the sweep, scan timing, enable priority, mode switching and
//   mid-scan reset; a randomized phase follows. Expected outputs come from a
//   behavioural model that tracks mode, index and remaining hold cycles.
// ---------------------------------------------------------------------------
module tb_decoder_nx_scan;

   localparam int N       = 2;
   localparam int OUT_W   = 4;
   localparam int DWELL_W = 8;

   logic               clk;
   logic               rst_n;
   logic               en;
   logic               mode;
   logic [N-1:0]       in;
   logic               in_valid;
   logic [DWELL_W-1:0] dwell;
   logic [OUT_W-1:0]   result;
   logic [N-1:0]       idx;
   logic               out_valid;
   logic               wrap;
   logic [OUT_W-1:0]   result_al;
   logic [N-1:0]       idx_al;
   logic               out_valid_al;
   logic               wrap_al;

   decoder_nx_scan #(.N(N), .DWELL_W(DWELL_W), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in),
      .in_valid(in_valid), .dwell(dwell), .result(result), .idx(idx),
      .out_valid(out_valid), .wrap(wrap)
   );

   decoder_nx_scan #(.N(N), .DWELL_W(DWELL_W), .ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in),
      .in_valid(in_valid), .dwell(dwell), .result(result_al), .idx(idx_al),
      .out_valid(out_valid_al), .wrap(wrap_al)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // m_kind: 0 = idle, 1 = direct decode, 2 = scanning
   int m_kind;
   int m_idx;
   int m_left;    // cycles still to be spent on the current scan index
   int m_valid;
   int m_wrap;

   function automatic void model_reset();
      m_kind  = 0;
      m_idx   = 0;
      m_left  = 0;
      m_valid = 0;
      m_wrap  = 0;
   endfunction

   function automatic void model_step(input int e, input int md, input int v,
                                      input int sel, input int dw);
      m_wrap = 0;
      if (e == 0) begin
         m_kind  = 0;
         m_valid = 0;
      end else if (md == 1 && m_kind != 2) begin
         // start scanning from the first output
         m_kind  = 2;
         m_idx   = 0;
         m_left  = dw;
         m_valid = 1;
      end else if (md == 0) begin
         if (v == 1) m_idx = sel;
         if (m_kind != 0 || v == 1) begin
            m_kind  = 1;
            m_valid = 1;
         end
      end else begin
         // scanning: step once the hold time is used up
         if (m_left == 0) begin
            m_idx  = (m_idx + 1) % OUT_W;
            m_wrap = (m_idx == 0) ? 1 : 0;
            m_left = dw;
         end else begin
            m_left = m_left - 1;
         end
      end
   endfunction

   task automatic compare_all(input string tag);
      logic [31:0] exp_res;
      exp_res = m_valid ? (32'd1 << m_idx) : 32'd0;
      check({tag, ".result"},    {28'd0, result},    exp_res);
      check({tag, ".result_al"}, {28'd0, result_al}, (~exp_res) & 32'hF);
      check({tag, ".idx"},       {30'd0, idx},       m_idx);
      check({tag, ".out_valid"}, {31'd0, out_valid}, m_valid);
      check({tag, ".wrap"},      {31'd0, wrap},      m_wrap);
   endtask

   // Called at a falling edge: apply inputs, let one rising edge pass,
   // then check at the next falling edge.
   task automatic do_cycle(input string tag, input int e, input int md, input int v,
                           input int sel, input int dw);
      en       = e[0];
      mode     = md[0];
      in_valid = v[0];
      in       = sel[N-1:0];
      dwell    = dw[DWELL_W-1:0];
      model_step(e, md, v, sel, dw);
      @(negedge clk);
      compare_all(tag);
      $display("cyc %s en=%0d mode=%0d iv=%0d in=%0d dw=%0d -> idx=%0d res=%h ov=%0d wrap=%0d",
               tag, e, md, v, sel, dw, idx, result, out_valid, wrap);
   endtask

   // Reset pulse entirely between clock edges (called at a falling edge).
   task automatic pulse_reset(input string tag);
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all(tag);
      $display("rst %s -> idx=%0d res=%h res_al=%h ov=%0d", tag, idx, result, result_al, out_valid);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int md_r;
      rst_n    = 1'b1;
      en       = 1'b0;
      mode     = 1'b0;
      in       = '0;
      in_valid = 1'b0;
      dwell    = '0;
      model_reset();

      // Reset asserted before the first rising edge.
      #2 rst_n = 1'b0;
      #1 compare_all("reset");
      @(negedge clk);
      compare_all("reset_held");
      rst_n = 1'b1;

      // Idle with enable high but nothing requested.
      do_cycle("idle", 1, 0, 0, 2, 0);

      // Direct sweep.
      for (int i = 0; i < OUT_W; i++) do_cycle("sweep", 1, 0, 1, i, 0);
      do_cycle("hold", 1, 0, 0, 1, 0);

      // Enable drop beats a simultaneous load.
      do_cycle("en_prio", 0, 0, 1, 3, 0);
      do_cycle("idle2", 0, 1, 1, 1, 0);

      // Scan with dwell=2, long enough for a wrap.
      for (int i = 0; i < 15; i++) do_cycle("scan_d2", 1, 1, 1, 3, 2);
      // dwell=0 steps every cycle.
      for (int i = 0; i < 6; i++) do_cycle("scan_d0", 1, 1, 0, 0, 0);

      // Mode switch from scan at idx=2.
      do_cycle("dis", 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) do_cycle("to_idx2", 1, 1, 0, 0, 0);
      do_cycle("scan2dir", 1, 0, 0, 1, 0);
      do_cycle("dir_hold", 1, 0, 0, 3, 0);
      do_cycle("dir2scan", 1, 1, 1, 3, 5);

      // Mid-scan reset at idx=3.
      for (int i = 0; i < 8 && m_idx != 3; i++) do_cycle("to_idx3", 1, 1, 0, 0, 0);
      check("reach_idx3", {30'd0, idx}, 32'd3);
      pulse_reset("rst_mid");
      do_cycle("after_rst", 1, 1, 0, 0, 1);

      // Randomized phase.
      md_r = 0;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 7) == 0) md_r = 1 - md_r;
         if ($urandom_range(0, 99) < 2) begin
            pulse_reset("rnd_rst");
         end else begin
            do_cycle("rnd",
                     ($urandom_range(0, 9) == 0) ? 0 : 1,
                     md_r,
                     int'($urandom_range(0, 1)),
                     int'($urandom_range(0, OUT_W - 1)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 1)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
